// File: rtl/coin_pkg.sv
// Shared definitions for the coin signalling link: colour codes, frame encodings and
// transmitter states. The transmitter and the decoder both import this package.
package coin_pkg;

  localparam logic [1:0] COLOR_00  = 2'b00;
  localparam logic [1:0] COLOR_01  = 2'b01;
  localparam logic [1:0] COLOR_10  = 2'b10;
  localparam logic [1:0] COLOR_INV = 2'b11;

  localparam int FRAME_BITS = 3;

  localparam logic [FRAME_BITS-1:0] ENC_01_DEF = 3'b001;
  localparam logic [FRAME_BITS-1:0] ENC_10_DEF = 3'b011;

  typedef enum logic [1:0] {
    IDLE,
    START,
    BIT,
    GAP
  } state_e;

  // Colour 00 is fixed at all-zero; the invalid colour maps to zero but is never framed.
  function automatic logic [FRAME_BITS-1:0] encode_color(
    input logic [1:0]            color,
    input logic [FRAME_BITS-1:0] enc_01,
    input logic [FRAME_BITS-1:0] enc_10
  );
    case (color)
      COLOR_01: return enc_01;
      COLOR_10: return enc_10;
      default:  return '0;
    endcase
  endfunction

endpackage

// File: rtl/coin_tx.sv
// Coin frame transmitter: accepts a colour over valid/ready and sends a start pulse
// followed by the colour's 3-bit pattern MSB first, then holds off for GAP_CYCLES.
module coin_tx
  import coin_pkg::*;
#(
  parameter int                    GAP_CYCLES = 2,
  parameter logic [FRAME_BITS-1:0] ENC_01     = ENC_01_DEF,
  parameter logic [FRAME_BITS-1:0] ENC_10     = ENC_10_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic [1:0] req_color,
  output logic       req_ready,
  output logic       start,
  output logic       coin,
  output logic       busy,
  output logic       err
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam int CW = $clog2(FRAME_BITS);
  localparam logic [CW-1:0] CNT_TOP = CW'(FRAME_BITS - 1);

  state_e                state_q, state_d;
  logic [FRAME_BITS-1:0] pattern_q, pattern_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic                  err_d;

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    err_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_color == COLOR_INV) begin
            err_d = 1'b1;
          end else begin
            pattern_d = encode_color(req_color, ENC_01, ENC_10);
            state_d   = START;
          end
        end
      end
      START: begin
        state_d = BIT;
        cnt_d   = CNT_TOP;
      end
      BIT: begin
        if (cnt_q == '0) begin
          gap_d   = '0;
          state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) state_d = IDLE;
        else                   gap_d   = gap_q + GW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every port comes straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pattern_q <= '0;
      cnt_q     <= '0;
      gap_q     <= '0;
      start     <= 1'b0;
      coin      <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      start     <= (state_d == START);
      coin      <= (state_d == BIT) && pattern_d[cnt_d];
      busy      <= (state_d != IDLE);
      err       <= err_d;
      req_ready <= (state_d == IDLE);
    end
  end

endmodule

// File: tb/tb_coin_tx.sv
// Self-checking bench for coin_tx: a timeline model of accepted frames predicts every
// output per cycle, and a bench-side decoder maps the sent coin bits back to colours.
module tb_coin_tx;

  localparam int MAXC = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid_a = 1'b0, valid_b = 1'b0;
  logic [1:0] color_a = 2'b00, color_b = 2'b00;
  logic       ready_a, start_a, coin_a, busy_a, err_a;
  logic       ready_b, start_b, coin_b, busy_b, err_b;

  always #5 clk = ~clk;

  coin_tx dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (valid_a),
    .req_color (color_a),
    .req_ready (ready_a),
    .start     (start_a),
    .coin      (coin_a),
    .busy      (busy_a),
    .err       (err_a)
  );

  coin_tx #(
    .GAP_CYCLES (0),
    .ENC_01     (3'b001),
    .ENC_10     (3'b100)
  ) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (valid_b),
    .req_color (color_b),
    .req_ready (ready_b),
    .start     (start_b),
    .coin      (coin_b),
    .busy      (busy_b),
    .err       (err_b)
  );

  int vectors = 0;
  int miscompares = 0;

  // Per-cycle stimulus and traces; trace bits are {start, coin, busy, err, req_ready}.
  logic       sv [MAXC];
  logic [1:0] sc [MAXC];
  logic [4:0] exp_t [MAXC];
  logic [4:0] obs_t [MAXC];
  logic [1:0] exp_dec[$];
  logic [1:0] obs_dec[$];

  bit         use_b;
  int         cur_gap;
  logic [2:0] cur_e01, cur_e10;

  task automatic select_dut(input bit b);
    use_b   = b;
    cur_gap = b ? 0 : 2;
    cur_e01 = 3'b001;
    cur_e10 = b ? 3'b100 : 3'b011;
  endtask

  task automatic clear_stim();
    for (int c = 0; c < MAXC; c++) begin
      sv[c] = 1'b0;
      sc[c] = 2'($urandom_range(0, 3));
    end
  endtask

  function automatic void build_model(input int len);
    int free;
    logic [2:0] p;
    exp_dec.delete();
    for (int c = 0; c < MAXC; c++) exp_t[c] = 5'b00001;
    free = 0;
    for (int c = 0; c < len; c++) begin
      if (sv[c] && c >= free) begin
        if (sc[c] == 2'b11) begin
          exp_t[c+1][1] = 1'b1;
        end else begin
          p = (sc[c] == 2'b00) ? 3'b000 : (sc[c] == 2'b01) ? cur_e01 : cur_e10;
          for (int k = 1; k <= 4 + cur_gap; k++) begin
            exp_t[c+k][2] = 1'b1;
            exp_t[c+k][0] = 1'b0;
          end
          exp_t[c+1][4] = 1'b1;
          exp_t[c+2][3] = p[2];
          exp_t[c+3][3] = p[1];
          exp_t[c+4][3] = p[0];
          exp_dec.push_back(sc[c]);
          free = c + 5 + cur_gap;
        end
      end
    end
  endfunction

  // Entered just after a rising edge; samples each cycle on the falling edge.
  task automatic play(input int len);
    for (int c = 0; c < len; c++) begin
      if (use_b) begin
        valid_b = sv[c];
        color_b = sc[c];
      end else begin
        valid_a = sv[c];
        color_a = sc[c];
      end
      @(negedge clk);
      obs_t[c] = use_b ? {start_b, coin_b, busy_b, err_b, ready_b}
                       : {start_a, coin_a, busy_a, err_a, ready_a};
      @(posedge clk);
      #1;
    end
    valid_a = 1'b0;
    valid_b = 1'b0;
  endtask

  function automatic void decode_obs(input int len);
    logic [2:0] pat;
    obs_dec.delete();
    for (int c = 0; c + 3 < len; c++) begin
      if (obs_t[c][4]) begin
        pat = {obs_t[c+1][3], obs_t[c+2][3], obs_t[c+3][3]};
        if (pat == 3'b000)       obs_dec.push_back(2'b00);
        else if (pat == cur_e01) obs_dec.push_back(2'b01);
        else if (pat == cur_e10) obs_dec.push_back(2'b10);
        else                     obs_dec.push_back(2'b11);
      end
    end
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({start_a, coin_a, busy_a, err_a, start_b, coin_b, busy_b, err_b} !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL reset_hold: outputs a/b %b%b%b%b %b%b%b%b expected all 0",
               start_a, coin_a, busy_a, err_a, start_b, coin_b, busy_b, err_b);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      vectors++;
      if ({start_a, coin_a, busy_a, err_a, ready_a, start_b, coin_b, busy_b, err_b, ready_b}
          !== 10'b00001_00001) begin
        miscompares++;
        $display("[TB] FAIL reset_idle cycle %0d: a=%b%b%b%b%b b=%b%b%b%b%b expected 00001 each",
                 c, start_a, coin_a, busy_a, err_a, ready_a,
                 start_b, coin_b, busy_b, err_b, ready_b);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_color01();
    select_dut(1'b0);
    clear_stim();
    sv[1] = 1'b1;
    sc[1] = 2'b01;
    build_model(12);
    play(12);
    for (int c = 0; c < 12; c++) begin
      vectors++;
      if (obs_t[c] !== exp_t[c]) begin
        miscompares++;
        $display("[TB] FAIL color01 cycle %0d: start/coin/busy/err/ready got %b expected %b",
                 c, obs_t[c], exp_t[c]);
      end
    end
    decode_obs(12);
    vectors++;
    if (obs_dec.size() != 1 || obs_dec[0] !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL color01_decode: got %0d frames (first %b) expected 1 frame 01",
               obs_dec.size(), (obs_dec.size() > 0) ? obs_dec[0] : 2'bxx);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    select_dut(1'b0);
    clear_stim();
    for (int c = 0; c < 21; c++) begin
      sv[c] = 1'b1;
      sc[c] = (c < 7) ? 2'b00 : (c < 14) ? 2'b10 : 2'b01;
    end
    build_model(28);
    play(28);
    for (int c = 0; c < 28; c++) begin
      vectors++;
      if (obs_t[c] !== exp_t[c]) begin
        miscompares++;
        $display("[TB] FAIL back_to_back cycle %0d: start/coin/busy/err/ready got %b expected %b",
                 c, obs_t[c], exp_t[c]);
      end
    end
    decode_obs(28);
    vectors++;
    ok = (obs_dec.size() == 3);
    if (ok) ok = (obs_dec[0] === 2'b00) && (obs_dec[1] === 2'b10) && (obs_dec[2] === 2'b01);
    if (!ok) begin
      miscompares++;
      $display("[TB] FAIL back_to_back_decode: got %0d frames, expected colours 00,10,01",
               obs_dec.size());
    end
  endtask

  task automatic test_invalid();
    select_dut(1'b0);
    clear_stim();
    sv[1] = 1'b1;
    sc[1] = 2'b11;
    sv[2] = 1'b1;
    sc[2] = 2'b10;
    build_model(14);
    play(14);
    for (int c = 0; c < 14; c++) begin
      vectors++;
      if (obs_t[c] !== exp_t[c]) begin
        miscompares++;
        $display("[TB] FAIL invalid cycle %0d: start/coin/busy/err/ready got %b expected %b",
                 c, obs_t[c], exp_t[c]);
      end
    end
    decode_obs(14);
    vectors++;
    if (obs_dec.size() != 1 || obs_dec[0] !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL invalid_decode: got %0d frames, expected 1 frame of colour 10",
               obs_dec.size());
    end
  endtask

  task automatic test_mid_reset();
    select_dut(1'b0);
    clear_stim();
    sv[1] = 1'b1;
    sc[1] = 2'b10;
    build_model(12);
    play(4);
    for (int c = 0; c < 4; c++) begin
      vectors++;
      if (obs_t[c] !== exp_t[c]) begin
        miscompares++;
        $display("[TB] FAIL mid_reset_pre cycle %0d: got %b expected %b", c, obs_t[c], exp_t[c]);
      end
    end
    // Cycle 4 carries the second coin bit (1 for pattern 011); reset lands inside it.
    rst_n = 1'b0;
    @(negedge clk);
    vectors++;
    if ({start_a, coin_a, busy_a, err_a} !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL mid_reset_drop: start/coin/busy/err got %b%b%b%b expected 0000",
               start_a, coin_a, busy_a, err_a);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      vectors++;
      if ({start_a, coin_a, busy_a, err_a, ready_a} !== 5'b00001) begin
        miscompares++;
        $display("[TB] FAIL mid_reset_after cycle %0d: got %b%b%b%b%b expected 00001",
                 c, start_a, coin_a, busy_a, err_a, ready_a);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_gap0();
    bit ok;
    select_dut(1'b1);
    clear_stim();
    for (int c = 0; c < 18; c++) begin
      sv[c] = 1'b1;
      sc[c] = 2'b10;
    end
    build_model(26);
    play(26);
    for (int c = 0; c < 26; c++) begin
      vectors++;
      if (obs_t[c] !== exp_t[c]) begin
        miscompares++;
        $display("[TB] FAIL gap0 cycle %0d: start/coin/busy/err/ready got %b expected %b",
                 c, obs_t[c], exp_t[c]);
      end
    end
    decode_obs(26);
    vectors++;
    ok = (obs_dec.size() == 4);
    foreach (obs_dec[i]) if (obs_dec[i] !== 2'b10) ok = 1'b0;
    if (!ok) begin
      miscompares++;
      $display("[TB] FAIL gap0_decode: got %0d frames, expected 4 frames of colour 10",
               obs_dec.size());
    end
  endtask

  task automatic test_random();
    bit ok;
    for (int iter = 0; iter < 4; iter++) begin
      select_dut(iter[0]);
      clear_stim();
      for (int c = 0; c < 40; c++) sv[c] = ($urandom_range(0, 2) != 0);
      build_model(48);
      play(48);
      for (int c = 0; c < 48; c++) begin
        vectors++;
        if (obs_t[c] !== exp_t[c]) begin
          miscompares++;
          $display("[TB] FAIL random%0d cycle %0d: start/coin/busy/err/ready got %b expected %b",
                   iter, c, obs_t[c], exp_t[c]);
        end
      end
      decode_obs(48);
      vectors++;
      ok = (obs_dec.size() == exp_dec.size());
      if (ok) foreach (exp_dec[i]) if (obs_dec[i] !== exp_dec[i]) ok = 1'b0;
      if (!ok) begin
        miscompares++;
        $display("[TB] FAIL random%0d_decode: got %0d frames expected %0d",
                 iter, obs_dec.size(), exp_dec.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_color01();
    test_back_to_back();
    test_invalid();
    test_mid_reset();
    test_gap0();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/coin_tx.md
# coin_tx

Serial frame transmitter for the coin signalling link: drives the `start`/`coin` pair that the coin colour decoder samples. Accepts a 2-bit colour request over a valid/ready handshake and emits a one-cycle `start` pulse followed by a 3-bit `coin` pattern, MSB first, that the decoder maps back to the same colour. Sits between the stimulus/control logic and the decoder; colour code 2'b11 has no frame and is rejected.

## Interface

- `GAP_CYCLES`, default 2: idle cycles forced after the last coin bit before the next request is accepted (0 legal).
- `ENC_01`, default 3'b001: coin pattern sent for colour 2'b01 (legal alternatives: 3'b110).
- `ENC_10`, default 3'b011: coin pattern sent for colour 2'b10 (legal alternatives: 3'b100).
- Colour 2'b00 is always sent as 3'b000.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  colour request present.
- `req_color`  in  2  requested colour; sampled only on handshake.
- `req_ready`  out  1  block idle, request accepted this cycle if `req_valid`.
- `start`  out  1  frame start pulse, one cycle wide.
- `coin`  out  1  serial frame bit.
- `busy`  out  1  frame or gap in progress.
- `err`  out  1  one-cycle pulse: colour 2'b11 was accepted and dropped.

## Operation

- States: IDLE, START, BIT, GAP.
- IDLE: `req_ready`=1. On `req_valid`&&`req_ready` at an edge:
  - colour 00/01/10: latch the encoded pattern into a 3-bit shift register, go to START.
  - colour 11: stay in IDLE, pulse `err` the next cycle; no `start`, no `coin`.
- START: `start`=1, `coin`=0, go to BIT with bit counter = 2.
- BIT: `coin` = pattern[counter]; at each edge the counter decrements; after bit 0, go to GAP (or IDLE if `GAP_CYCLES`=0).
- GAP: all outputs 0 except `busy`; count `GAP_CYCLES` cycles, then go to IDLE.
- `busy` = 1 in START, BIT and GAP. `req_ready` = 1 only in IDLE.
- `req_color` is not re-sampled after the handshake; changes mid-frame have no effect.
- `req_valid` outside IDLE is ignored. Requests are not queued.

## Timing

- All outputs are registered.
- Reset values: `start`=0, `coin`=0, `busy`=0, `err`=0, state IDLE, so `req_ready`=1 once `rst_n` is high.
- Handshake at the edge ending cycle N:
  - `start`=1 in cycle N+1.
  - coin bits b2, b1, b0 in cycles N+2, N+3, N+4.
  - gap in cycles N+5 .. N+4+GAP_CYCLES.
  - `req_ready` returns in cycle N+5+GAP_CYCLES.
- Frame period: 4+GAP_CYCLES cycles for one frame, plus the accept cycle. Back-to-back minimum is 5 cycles with GAP_CYCLES=0.
- Colour-11 reject: `err`=1 in cycle N+1, and `req_ready` stays 1 throughout.
- Reset asserted mid-frame: all outputs drop to 0 immediately (asynchronous), the partial frame is abandoned, and the state returns to IDLE. No frame resumes after release.

## Structure

- Shared package `coin_pkg` holds:
  - colour constants `COLOR_00`, `COLOR_01`, `COLOR_10`, `COLOR_INV`;
  - default encodings `ENC_01_DEF`, `ENC_10_DEF`;
  - the state enum;
  - the frame length constant `FRAME_BITS`=3.
- The decoder should import the same package so that encodings cannot diverge.
- No sub-module. The encoder is a package function; the FSM, shift register and gap counter live in `coin_tx`.

## Test plan

- Reset then idle: hold `rst_n`=0 for 2 cycles, release. Expect `req_ready`=1, `start`/`coin`/`busy`/`err`=0, and no activity for 5 cycles.
- Colour 01 (defaults): handshake in cycle N. Expect `start`=1 at N+1, `coin` 0,0,1 at N+2..N+4, `busy`=1 at N+1..N+6, `req_ready`=1 at N+7. A looped-back decoder reports 2'b01.
- All colours back-to-back with `req_valid` held high and colours 00, 10, 01 queued by the bench:
  - frames follow 7 cycles apart;
  - patterns are 000, 011, 001;
  - decoder outputs match each colour.
- Colour 11: handshake. Expect `err`=1 for exactly one cycle, no `start` pulse, and `req_ready` never deasserted. A colour-10 request in the following cycle is then sent normally as 011.
- Mid-frame reset: assert `rst_n`=0 during the second coin bit of a colour-10 frame. Expect `coin`/`start`/`busy` to go to 0 in the same cycle and `req_ready`=1 after release, with no residual bits.
- `GAP_CYCLES`=0 with `ENC_10`=3'b100: continuous colour-10 requests. Expect `start` every 5 cycles, each followed by coin 1,0,0.
